// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the configurable serial receiver.
// States, parity modes and fixed widths used by serial_rx_multi and its bench.
package serial_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } rxState_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Wide enough for up to 9 data bits or 2 stop bits.
   localparam int BIT_CTR_W = 4;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line.
// With SERIAL_RX_MAJORITY_EN defined, s_o is a 3-sample majority vote.
module rx_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rx_i,
   output logic rx_s_o,
   output logic s_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], rx_i};
      end
   end

   assign rx_s_o = sync_q[1];

`ifdef SERIAL_RX_MAJORITY_EN
   // Two previous rx_s values; with the current one they form the 3-sample window.
   logic [1:0] hist_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hist_q <= '0;
      end else begin
         hist_q <= {hist_q[0], sync_q[1]};
      end
   end

   assign s_o = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign s_o = sync_q[1];
`endif

endmodule

// File: rtl/serial_rx_multi.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1 or 2 stop bits,
// framing/parity error flags and break detection. Optional macro: SERIAL_RX_MAJORITY_EN.
module serial_rx_multi
   import serial_rx_pkg::*;
#(
   parameter int CLK_PER_BIT = 2604,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 new_data_o,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 break_det_o
);

   localparam int CW = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] CTR_HALF = CW'(CLK_PER_BIT >> 1);
   localparam logic [CW-1:0] CTR_LAST = CW'(CLK_PER_BIT - 1);
   localparam logic [BIT_CTR_W-1:0] DATA_LAST = BIT_CTR_W'(DATA_BITS - 1);
   localparam logic [BIT_CTR_W-1:0] STOP_LAST = BIT_CTR_W'(STOP_BITS - 1);

   logic rxSync;
   logic s;

   rx_sync uSync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .rx_i   (rx_i),
      .rx_s_o (rxSync),
      .s_o    (s)
   );

   rxState_e               state_q, state_d;
   logic [CW-1:0]          ctr_q, ctr_d;
   logic [BIT_CTR_W-1:0]   bitCtr_q, bitCtr_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   parBit_q, parBit_d;
   logic                   parErr_q, parErr_d;
   logic                   frmErr_q, frmErr_d;
   logic                   stop0_q, stop0_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   newData_q, newData_d;
   logic                   parErrOut_q, parErrOut_d;
   logic                   frmErrOut_q, frmErrOut_d;
   logic                   break_q, break_d;
   logic                   firstStop;
   logic                   isBreak;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_WAIT_HIGH;
         ctr_q       <= '0;
         bitCtr_q    <= '0;
         shreg_q     <= '0;
         parBit_q    <= 1'b0;
         parErr_q    <= 1'b0;
         frmErr_q    <= 1'b0;
         stop0_q     <= 1'b0;
         data_q      <= '0;
         newData_q   <= 1'b0;
         parErrOut_q <= 1'b0;
         frmErrOut_q <= 1'b0;
         break_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         bitCtr_q    <= bitCtr_d;
         shreg_q     <= shreg_d;
         parBit_q    <= parBit_d;
         parErr_q    <= parErr_d;
         frmErr_q    <= frmErr_d;
         stop0_q     <= stop0_d;
         data_q      <= data_d;
         newData_q   <= newData_d;
         parErrOut_q <= parErrOut_d;
         frmErrOut_q <= frmErrOut_d;
         break_q     <= break_d;
      end
   end

   // Every sample point clears ctr so bits are spaced exactly one bit time apart.
   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q + CW'(1);
      bitCtr_d    = bitCtr_q;
      shreg_d     = shreg_q;
      parBit_d    = parBit_q;
      parErr_d    = parErr_q;
      frmErr_d    = frmErr_q;
      stop0_d     = stop0_q;
      data_d      = data_q;
      newData_d   = 1'b0;
      parErrOut_d = 1'b0;
      frmErrOut_d = 1'b0;
      break_d     = 1'b0;
      firstStop   = (bitCtr_q == '0) ? s : stop0_q;
      isBreak     = (shreg_q == '0) && ((PARITY == PAR_NONE) || !parBit_q) && !firstStop;

      case (state_q)
         ST_IDLE: begin
            ctr_d    = '0;
            bitCtr_d = '0;
            parErr_d = 1'b0;
            frmErr_d = 1'b0;
            if (!rxSync) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (ctr_q == CTR_HALF) begin
               ctr_d   = '0;
               state_d = s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (ctr_q == CTR_LAST) begin
               ctr_d    = '0;
               shreg_d  = {s, shreg_q[DATA_BITS-1:1]};
               bitCtr_d = bitCtr_q + BIT_CTR_W'(1);
               if (bitCtr_q == DATA_LAST) begin
                  bitCtr_d = '0;
                  state_d  = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (ctr_q == CTR_LAST) begin
               ctr_d    = '0;
               parBit_d = s;
               parErr_d = (PARITY == PAR_ODD) ? ~(^shreg_q ^ s) : (^shreg_q ^ s);
               state_d  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (ctr_q == CTR_LAST) begin
               ctr_d    = '0;
               bitCtr_d = bitCtr_q + BIT_CTR_W'(1);
               if (!s) begin
                  frmErr_d = 1'b1;
               end
               if (bitCtr_q == '0) begin
                  stop0_d = s;
               end
               if (bitCtr_q == STOP_LAST) begin
                  bitCtr_d = '0;
                  if (isBreak) begin
                     break_d = 1'b1;
                     state_d = ST_WAIT_HIGH;
                  end else begin
                     data_d      = shreg_q;
                     newData_d   = 1'b1;
                     parErrOut_d = parErr_q;
                     frmErrOut_d = frmErr_q | ~s;
                     state_d     = s ? ST_IDLE : ST_WAIT_HIGH;
                  end
               end
            end
         end
         ST_WAIT_HIGH: begin
            ctr_d    = '0;
            bitCtr_d = '0;
            if (rxSync) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            ctr_d    = '0;
            bitCtr_d = '0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   assign data_o       = data_q;
   assign new_data_o   = newData_q;
   assign parity_err_o = parErrOut_q;
   assign frame_err_o  = frmErrOut_q;
   assign break_det_o  = break_q;

endmodule

// File: tb/tb_serial_rx_multi.sv
// Scoreboard bench for serial_rx_multi: an 8N1 instance (A) and a 7E2 instance (B),
// both at 16 clocks per bit. The glitch-rejection test runs only with SERIAL_RX_MAJORITY_EN.
module tb_serial_rx_multi;

   localparam int BIT = 16;

   typedef struct {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } expT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxA = 1'b1;
   logic       rxB = 1'b1;
   logic [7:0] dataA;
   logic       newDataA, parErrA, frmErrA, brkA;
   logic [6:0] dataB;
   logic       newDataB, parErrB, frmErrB, brkB;

   expT qA[$];
   expT qB[$];
   int  breakA = 0, breakB = 0, nDataA = 0;
   int  errCount = 0, checkCount = 0;

   always #5 clk = ~clk;

   serial_rx_multi #(.CLK_PER_BIT(BIT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .rx_i         (rxA),
      .data_o       (dataA),
      .new_data_o   (newDataA),
      .parity_err_o (parErrA),
      .frame_err_o  (frmErrA),
      .break_det_o  (brkA)
   );

   serial_rx_multi #(.CLK_PER_BIT(BIT), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dutB (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .rx_i         (rxB),
      .data_o       (dataB),
      .new_data_o   (newDataB),
      .parity_err_o (parErrB),
      .frame_err_o  (frmErrB),
      .break_det_o  (brkB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Each new_data pulse is matched against the oldest expected frame.
   always @(negedge clk) begin
      expT e;
      if (brkA) breakA++;
      if (brkB) breakB++;
      if (newDataA) begin
         nDataA++;
         if (qA.size() == 0) begin
            checkOutput("A spurious new_data", 32'd1, 32'd0);
         end else begin
            e = qA.pop_front();
            checkOutput("A data", 32'(dataA), 32'(e.data));
            checkOutput("A parity_err", 32'(parErrA), 32'(e.perr));
            checkOutput("A frame_err", 32'(frmErrA), 32'(e.ferr));
         end
      end
      if (newDataB) begin
         if (qB.size() == 0) begin
            checkOutput("B spurious new_data", 32'd1, 32'd0);
         end else begin
            e = qB.pop_front();
            checkOutput("B data", 32'(dataB), 32'(e.data));
            checkOutput("B parity_err", 32'(parErrB), 32'(e.perr));
            checkOutput("B frame_err", 32'(frmErrB), 32'(e.ferr));
         end
      end
   end

   task automatic setLine(input int which, input logic v);
      if (which == 0) rxA = v;
      else rxB = v;
   endtask

   task automatic driveLine(input int which, input logic v, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         setLine(which, v);
      end
   endtask

   // Frame bits LSB first: start, data, optional parity, stop bits.
   function automatic logic [15:0] frameBits(input logic [8:0] d, input int nData, input bit usePar,
                                             input logic p, input int nStop, input logic st0, input logic st1);
      logic [15:0] f;
      int k;
      f = '1;
      f[0] = 1'b0;
      k = 1;
      for (int i = 0; i < nData; i++) begin
         f[k] = d[i];
         k++;
      end
      if (usePar) begin
         f[k] = p;
         k++;
      end
      f[k] = st0;
      k++;
      if (nStop == 2) f[k] = st1;
      return f;
   endfunction

   // Glitch inverts the line for one cycle at each bit's sample point (offset 9 from bit start).
   task automatic applyStimulus(input int which, input logic [15:0] bits, input int nBits, input bit glitch);
      logic v;
      for (int c = 0; c < nBits * BIT; c++) begin
         v = bits[c / BIT];
         if (glitch && (c % BIT) == 9) v = ~v;
         @(negedge clk);
         setLine(which, v);
      end
   endtask

   task automatic sendA(input logic [7:0] d, input logic st0, input bit glitch, input logic perr, input logic ferr);
      qA.push_back('{data: {1'b0, d}, perr: perr, ferr: ferr});
      applyStimulus(0, frameBits({1'b0, d}, 8, 1'b0, 1'b0, 1, st0, 1'b1), 10, glitch);
   endtask

   task automatic sendB(input logic [6:0] d, input logic p);
      qB.push_back('{data: {2'b00, d}, perr: (^d) ^ p, ferr: 1'b0});
      applyStimulus(1, frameBits({2'b00, d}, 7, 1'b1, p, 2, 1'b1, 1'b1), 12, 1'b0);
   endtask

   task automatic waitDrain(input int which, input string tag);
      int n = 0;
      while (((which == 0) ? qA.size() : qB.size()) != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 32'((which == 0) ? qA.size() : qB.size()), 32'd0);
   endtask

   initial begin
      int savedBreak, savedN;

      repeat (3) @(negedge clk);
      checkOutput("reset A data", 32'(dataA), 32'd0);
      checkOutput("reset A new_data", 32'(newDataA), 32'd0);
      checkOutput("reset A parity_err", 32'(parErrA), 32'd0);
      checkOutput("reset A frame_err", 32'(frmErrA), 32'd0);
      checkOutput("reset A break_det", 32'(brkA), 32'd0);
      checkOutput("reset B data", 32'(dataB), 32'd0);
      rst_n = 1'b1;
      driveLine(0, 1'b1, 20);

      $display("[TB] 8N1 back-to-back 0xA5, 0x3C");
      sendA(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      sendA(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      driveLine(0, 1'b1, 20);
      waitDrain(0, "A back-to-back drained");

      $display("[TB] 7E2 parity good and bad");
      sendB(7'h55, 1'b0);
      sendB(7'h55, 1'b1);
      driveLine(1, 1'b1, 20);
      waitDrain(1, "B parity drained");

      $display("[TB] frame error then line held low");
      sendA(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
      driveLine(0, 1'b0, 40);
      driveLine(0, 1'b1, 32);
      waitDrain(0, "A frame error drained");

      $display("[TB] break for 12 bit times");
      savedBreak = breakA;
      savedN = nDataA;
      driveLine(0, 1'b0, 12 * BIT);
      driveLine(0, 1'b1, 32);
      checkOutput("A break pulses", 32'(breakA - savedBreak), 32'd1);
      checkOutput("A no new_data on break", 32'(nDataA - savedN), 32'd0);
      checkOutput("A data held after break", 32'(dataA), 32'h81);
      sendA(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
      driveLine(0, 1'b1, 20);
      waitDrain(0, "A after break drained");

      $display("[TB] short idle glitch");
      savedN = nDataA;
      savedBreak = breakA;
      driveLine(0, 1'b0, 4);
      driveLine(0, 1'b1, 3 * BIT);
      checkOutput("A glitch new_data", 32'(nDataA - savedN), 32'd0);
      checkOutput("A glitch break", 32'(breakA - savedBreak), 32'd0);

      $display("[TB] reset mid-byte with line low");
      driveLine(0, 1'b0, 30);
      rst_n = 1'b0;
      driveLine(0, 1'b0, 5);
      checkOutput("midreset A data", 32'(dataA), 32'd0);
      checkOutput("midreset A new_data", 32'(newDataA), 32'd0);
      rst_n = 1'b1;
      savedN = nDataA;
      driveLine(0, 1'b0, 40);
      driveLine(0, 1'b1, 24);
      checkOutput("A no frame after reset", 32'(nDataA - savedN), 32'd0);
      sendA(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      driveLine(0, 1'b1, 20);
      waitDrain(0, "A after reset drained");

`ifdef SERIAL_RX_MAJORITY_EN
      $display("[TB] majority vote with sample-point glitches");
      sendA(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
      driveLine(0, 1'b1, 20);
      waitDrain(0, "A majority drained");
`endif

      checkOutput("B break pulses", 32'(breakB), 32'd0);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/serial_rx_multi.md
Name: serial_rx_multi

Overview:
- Parametrised successor to the fixed 8N1 UART receiver. Supports configurable data width, parity, stop-bit count and line error reporting.
- Sits between the board's asynchronous RX pin and the command/byte decoders. It presents each received word with a one-cycle valid pulse.
- Adds an input synchroniser, false-start rejection, parity checking, framing-error reporting and break detection.

Parameters:
- CLK_PER_BIT, 2604: clk cycles per bit; minimum 8.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial line; idle high.
- data  out  DATA_BITS  last received word; holds until the next completed frame.
- new_data  out  1  one-cycle pulse when data is updated.
- parity_err  out  1  pulse with new_data if the parity check failed; always 0 when PARITY = 0.
- frame_err  out  1  pulse with new_data if any stop bit sampled 0.
- break_det  out  1  one-cycle pulse on a break condition.

Behaviour:
- Reset (rst low, asynchronous):
  - data = 0; new_data, parity_err, frame_err, break_det = 0.
  - Synchroniser flops = 0; counters = 0; state = WAIT_HIGH.
  - Consequence: a frame already in flight when reset releases is ignored until the line returns high.
- Input path: 2-FF synchroniser gives rx_s. Sampled bit value "s" = rx_s, or the majority value (see Optional Feature).
- States:
  - IDLE: ctr = 0, bit_ctr = 0. rx_s == 0 -> START.
  - START: count to CLK_PER_BIT>>1, then sample. s == 1 -> IDLE (false start, no outputs). s == 0 -> DATA, ctr = 0.
  - DATA: sample at ctr == CLK_PER_BIT-1, then ctr = 0. Shift in from the MSB: shreg = {s, shreg[DATA_BITS-1:1]}. After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
  - PARITY: sample one bit time later.
    - Odd mode: error when XOR(data, p) == 0.
    - Even mode: error when XOR(data, p) == 1.
    - Result is held in a pending flag.
  - STOP: sample STOP_BITS bits, one bit time apart. Any 0 sets pending frame error. On the last stop sample, next cycle:
    - Break: all data bits 0, parity bit 0 (if present) and first stop bit 0. Pulse break_det only; data, new_data and flags are not updated. -> WAIT_HIGH.
    - Otherwise: register data = shreg; pulse new_data with parity_err/frame_err. -> IDLE if the last stop bit = 1, else WAIT_HIGH.
  - WAIT_HIGH: rx_s == 1 -> IDLE.
- Latency: new_data rises 1 cycle after the last stop-bit sample point, which is itself 2 cycles after the line because of the synchroniser.
- Illegal state encoding -> IDLE.
- Counter width is $clog2(CLK_PER_BIT). Both ctr and bit_ctr reset to 0 on every state transition.
- Back-to-back frames: a start edge may be accepted in IDLE on the cycle after STOP completes. No dead time is required beyond that.

Optional Feature:
- Macro: SERIAL_RX_MAJORITY_EN.
- Defined: a 3-deep history of rx_s is kept. Every sample (start check, data, parity, stop) uses the majority of the 3 most recent rx_s values, which rejects single-cycle glitches. Latency and sample points are unchanged.
- Undefined: s = rx_s directly; the history register is absent.

Decomposition:
- Package serial_rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN.
- Sub-module rx_sync holds the 2-FF synchroniser plus the optional majority history. Its outputs are rx_s and s.

Test Plan (CLK_PER_BIT=16 unless noted):
- 8N1: send 0xA5 then 0x3C back-to-back -> two new_data pulses, data = 0xA5 then 0x3C, no error flags.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2: send 0x55 with correct parity 0 -> new_data, parity_err=0. Resend with parity bit 1 -> new_data with parity_err=1, data=0x55.
- Stop bit driven 0, data 0x81 -> new_data with frame_err=1. Line then held low 40 cycles -> no new frame until rx returns high.
- Line held low for 12 bit times -> single break_det pulse, no new_data, data unchanged. Next valid 0x0F is received correctly.
- Glitch rx low for 4 cycles in idle -> no state change beyond START, no outputs.
- Assert rst mid-byte with rx low, release while still low -> no new_data. The following full frame 0xC3 is received correctly.
- With SERIAL_RX_MAJORITY_EN: 1-cycle inverted glitch at every sample point of 0x5A -> data = 0x5A.
